multdiv_arbiter: RTL and testbench

Shares a single multdiv unit between NUM_REQ requesters, such as pipeline ports. It accepts one operation at a time under round-robin arbitration and latches the operands. It issues a one-cycle ctrl_MULT or ctrl_DIV pulse and holds the operands stable until data_resultRDY. It then returns the result and exception flag to the winning requester, and a watchdog aborts operations that never complete.

---
 rtl/multdiv_arbiter_pkg.sv | 18 +
 rtl/multdiv_arbiter_rr_arbiter.sv | 41 ++++
 rtl/multdiv_arbiter.sv | 149 ++++++++++++++
 tb/tb_multdiv_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_arbiter_pkg.sv
// Shared definitions for the multdiv arbiter: FSM encoding, op codes, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multdiv_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_arbiter_rr_arbiter.sv
// Round-robin picker: first requester after last_grant (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports: req (per-requester valid), last_grant (index of previous winner),
//        grant (one-hot), grant_idx (binary), grant_vld (any request present).
module rr_arbiter
    import multdiv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    logic [IW-1:0] idx;

    // Walk last_grant+1, last_grant+2, ... with explicit wrap so that
    // non-power-of-two NUM_REQ never indexes past the request vector.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one multdiv unit between NUM_REQ requesters, one op at a time, round-robin.
// Latency: accept -> START pulse -> WAIT (>= MIN_LAT cycles) -> RESP one cycle after accepted RDY.
// Backpressure: req_ready only in IDLE; other requests are held by their owners until granted.
//
// Ports: clock/reset_n; req_valid/req_op/req_opA/req_opB in, req_ready one-hot accept;
//        rsp_valid one-hot with rsp_result/rsp_exception; busy; multdiv side:
//        data_operandA/B, ctrl_MULT/ctrl_DIV out, data_result/data_exception/data_resultRDY in.
module multdiv_arbiter
    import multdiv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter int MIN_LAT = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_opA,
    input  logic [DATA_W*NUM_REQ-1:0]   req_opB,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_exception,
    output logic                        busy,
    output logic [DATA_W-1:0]           data_operandA,
    output logic [DATA_W-1:0]           data_operandB,
    output logic                        ctrl_MULT,
    output logic                        ctrl_DIV,
    input  logic [DATA_W-1:0]           data_result,
    input  logic                        data_exception,
    input  logic                        data_resultRDY
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [IW-1:0]       last_grant, grant_r, arb_idx;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_vld;
    logic [DATA_W-1:0]   op_a, op_b, sel_a, sel_b, res_r;
    logic                op_r, sel_op, exc_r;
    logic [CW-1:0]       wait_cnt;
    logic                rdy_ok, tmo;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_gnt),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    // Operand mux for the current arbitration winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_MULT;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_a  = req_opA[i*DATA_W +: DATA_W];
                sel_b  = req_opB[i*DATA_W +: DATA_W];
                sel_op = req_op[i];
            end
        end
    end

    // RDY left high from the previous op must not complete a new one, so it
    // only counts once the first MIN_LAT WAIT cycles have passed.
    assign rdy_ok = (state == ST_WAIT) && data_resultRDY && (wait_cnt >= CW'(MIN_LAT));
    assign tmo    = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = arb_gnt;
                if (arb_vld) state_nxt = ST_START;
            end
            ST_START: begin
                ctrl_MULT = (op_r == OP_MULT);
                ctrl_DIV  = (op_r == OP_DIV);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rdy_ok || tmo) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[grant_r] = 1'b1;
                state_nxt          = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // req_ready is combinational from req_valid; keep it quiet while reset is held.
        if (!reset_n) req_ready = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            grant_r    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_r       <= OP_MULT;
            wait_cnt   <= '0;
            res_r      <= '0;
            exc_r      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        op_r       <= sel_op;
                        grant_r    <= arb_idx;
                        last_grant <= arb_idx;
                    end
                end
                ST_START: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    // A genuine result wins over the watchdog in the same cycle.
                    if (rdy_ok) begin
                        res_r <= data_result;
                        exc_r <= data_exception;
                    end else if (tmo) begin
                        res_r <= '0;
                        exc_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_operandA = op_a;
    assign data_operandB = op_b;
    assign rsp_result    = res_r;
    assign rsp_exception = exc_r;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Bench for multdiv_arbiter: stub multdiv plus a transaction-level reference model.
// Latency: n/a.
// Backpressure: requesters hold a request until it is accepted.
module tb_multdiv_arbiter;

    localparam int N  = 2;
    localparam int TO = 64;
    localparam int ML = 2;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic            clock;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_op, req_ready, rsp_valid;
    logic [32*N-1:0] req_opA, req_opB;
    logic [31:0]     rsp_result, data_operandA, data_operandB;
    logic            rsp_exception, busy, ctrl_MULT, ctrl_DIV;
    logic [31:0]     data_result    = 32'h0;
    logic            data_exception = 1'b0;
    logic            data_resultRDY = 1'b0;

    multdiv_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .MIN_LAT(ML)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_opA        (req_opA),
        .req_opB        (req_opB),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_result     (rsp_result),
        .rsp_exception  (rsp_exception),
        .busy           (busy),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Stub multdiv: mode 0 drops RDY on a new op and raises it stub_lat cycles
    // later; mode 1 keeps a stale RDY high; mode 2 never answers.
    int          stub_mode = 0;
    int          stub_lat  = 1;
    int          left      = 0;
    logic        s_op      = 1'b0;
    logic [31:0] s_a       = 32'h0;
    logic [31:0] s_b       = 32'h0;

    function automatic logic [32:0] md_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (op == 1'b0) begin
            p = {32'h0, a} * {32'h0, b};
            return {(p[63:32] != 32'h0), p[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        return {1'b0, a / b};
    endfunction

    always @(posedge clock) begin
        if (ctrl_MULT || ctrl_DIV) begin
            s_op <= ctrl_DIV;
            s_a  <= data_operandA;
            s_b  <= data_operandB;
            left <= (stub_mode == 2) ? 0 : stub_lat;
            if (stub_mode != 1) data_resultRDY <= 1'b0;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                data_resultRDY <= 1'b1;
                {data_exception, data_result} <= md_fn(s_op, s_a, s_b);
            end
        end
    end

    // Reference model state (transaction level).
    op_t         rq [N][$];
    int          gnt_log[$];
    int          lg = N - 1;
    bit          mb = 1'b0;
    int          t = 0, rt = 0, win = 0;
    logic        eop = 1'b0, eexc = 1'b0;
    logic [31:0] ea = 32'h0, eb = 32'h0, eres = 32'h0;
    int          fixed_lat = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int r, input logic op, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.op = op; o.a = a; o.b = b;
        rq[r].push_back(o);
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy, exp_rsp;
        logic [32:0]  r;
        op_t          o;
        int           w, k;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) begin
                req_op[i]           = rq[i][0].op;
                req_opA[i*32 +: 32] = rq[i][0].a;
                req_opB[i*32 +: 32] = rq[i][0].b;
            end
        end
        #1;
        exp_rdy = '0;
        w = -1;
        if (!mb) begin
            w = pick(req_valid, lg);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
        exp_rsp = '0;
        if (mb) begin
            t++;
            chk("busy", 64'(busy), 64'(1));
            chk("ctrl_mult", 64'(ctrl_MULT), 64'(t == 1 && eop == 1'b0));
            chk("ctrl_div", 64'(ctrl_DIV), 64'(t == 1 && eop == 1'b1));
            chk("operand_a", 64'(data_operandA), 64'(ea));
            chk("operand_b", 64'(data_operandB), 64'(eb));
            if (t == rt) exp_rsp[win] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
            if (t == rt) begin
                chk("rsp_result", 64'(rsp_result), 64'(eres));
                chk("rsp_exception", 64'(rsp_exception), 64'(eexc));
                mb = 1'b0;
            end
        end else begin
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        if (w >= 0) begin
            o   = rq[w].pop_front();
            mb  = 1'b1; t = 0; win = w; lg = w;
            eop = o.op; ea = o.a; eb = o.b;
            if (fixed_lat > 0) stub_lat = fixed_lat;
            else stub_lat = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 10);
            // Accepted at the first WAIT cycle where RDY is seen and the guard has passed.
            k = (stub_mode == 2) ? TO : ((stub_lat > ML) ? stub_lat : ML);
            if (k > TO - 1) begin
                k = TO - 1; eres = 32'h0; eexc = 1'b1;
            end else begin
                r = md_fn(eop, ea, eb); eexc = r[32]; eres = r[31:0];
            end
            rt = 3 + k;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((mb || pending()) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_bound", 64'(mb || pending()), 64'(0));
    endtask

    task automatic reset_check();
        @(negedge clock);
        reset_n   = 1'b0;
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ctrl", 64'({ctrl_MULT, ctrl_DIV}), 64'(0));
        chk("rst_operands", {data_operandA, data_operandB}, 64'(0));
        chk("rst_result", 64'({rsp_exception, rsp_result}), 64'(0));
        @(negedge clock);
        reset_n   = 1'b1;
        req_valid = '0;
        mb = 1'b0;
        lg = N - 1;
        gnt_log.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_order[4] = '{0, 1, 0, 1};
        int guard;
        reset_n = 1'b0; req_valid = '0; req_op = '0; req_opA = '0; req_opB = '0;
        reset_check();

        // Basic mult on requester 0, then div and divide-by-zero on requester 1.
        push(0, 1'b0, 32'd7, 32'd3);
        drain(200);
        chk("mult_7x3", 64'(rsp_result), 64'(21));
        chk("mult_exc", 64'(rsp_exception), 64'(0));
        fixed_lat = 4;
        push(1, 1'b1, 32'd7, 32'd3);
        drain(200);
        chk("div_7by3", 64'(rsp_result), 64'(2));
        push(1, 1'b1, 32'd7, 32'd0);
        drain(200);
        chk("div_by_zero_exc", 64'(rsp_exception), 64'(1));

        // Both requesters continuously valid from reset: alternate grants.
        reset_check();
        fixed_lat = 3;
        for (int i = 0; i < 2; i++) begin
            push(0, 1'($urandom), $urandom, $urandom_range(1, 999));
            push(1, 1'($urandom), $urandom, $urandom_range(1, 999));
        end
        drain(400);
        chk("grant_count", 64'(gnt_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk("grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));

        // Stale RDY held high: the guard must wait for the fresh result.
        stub_mode = 1; fixed_lat = 1;
        push(0, 1'b0, 32'd5, 32'd6);
        drain(200);
        chk("stale_rdy_result", 64'(rsp_result), 64'(30));

        // Multdiv never answers: watchdog aborts with exception.
        stub_mode = 2;
        push(1, 1'b1, 32'd100, 32'd5);
        drain(300);
        chk("timeout_result", 64'(rsp_result), 64'(0));
        chk("timeout_exc", 64'(rsp_exception), 64'(1));
        cycle();
        chk("timeout_back_idle", 64'(busy), 64'(0));

        // Reset during WAIT of a div; its late RDY must be ignored.
        stub_mode = 0; fixed_lat = 30;
        push(0, 1'b1, 32'd50, 32'd7);
        guard = 0;
        while (!(mb && t == 5) && guard < 50) begin
            cycle();
            guard++;
        end
        chk("reached_wait", 64'(guard < 50), 64'(1));
        reset_check();
        fixed_lat = 2;
        repeat (40) cycle();
        push(1, 1'b0, 32'd9, 32'd9);
        push(0, 1'b0, 32'd4, 32'd4);
        drain(200);
        chk("post_reset_first_grant", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'(0));

        // Randomized traffic.
        stub_mode = 0; fixed_lat = 0;
        repeat (40) begin
            if ($urandom_range(0, 1) == 1)
                push($urandom_range(0, N - 1), 1'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            repeat ($urandom_range(0, 3)) cycle();
        end
        drain(8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
